servile_wb_sched: RTL and testbench



---
 rtl/servile_wb_sched.sv | 213 +++++++++++++++++++++
 tb/tb_servile_wb_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servile_wb_sched.sv
// servile_wb_sched
//   Shares the single Servile memory port between the CPU instruction bus,
//   the CPU data bus and an auxiliary master. Grants are registered,
//   round-robin, and held for a whole transaction. The grant is never
//   pre-empted, and one idle cycle always follows each ack.
//
// Configuration macro:
//   SERVILE_WB_SCHED_TIMEOUT_EN - enables the bus-timeout watchdog. When it
//   times out, the granted master gets an ack with zero read data, and the
//   block pulses o_err and bumps o_err_count. When the macro is undefined,
//   BUSY waits for an ack indefinitely and o_err/o_err_count are constant 0.
//
// Parameters:
//   timeout_cycles   BUSY cycles without ack before the watchdog fires (2..255)
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_wb_ibus_*/o_wb_ibus_* instruction fetch master (read-only)
//   i_wb_dbus_*/o_wb_dbus_* CPU data master
//   i_wb_aux_*/o_wb_aux_*   auxiliary master (debug loader / DMA)
//   o_wb_mem_*/i_wb_mem_*   shared memory port
//   o_grant                 current owner: 0 ibus, 1 dbus, 2 aux, 3 none
//   o_err                   one-cycle timeout pulse
//   o_err_count             saturating timeout count
module servile_wb_sched #(
   parameter int unsigned timeout_cycles = 64
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_wb_ibus_adr,
   input  logic        i_wb_ibus_stb,
   output logic [31:0] o_wb_ibus_rdt,
   output logic        o_wb_ibus_ack,
   input  logic [31:0] i_wb_dbus_adr,
   input  logic [31:0] i_wb_dbus_dat,
   input  logic [3:0]  i_wb_dbus_sel,
   input  logic        i_wb_dbus_we,
   input  logic        i_wb_dbus_stb,
   output logic [31:0] o_wb_dbus_rdt,
   output logic        o_wb_dbus_ack,
   input  logic [31:0] i_wb_aux_adr,
   input  logic [31:0] i_wb_aux_dat,
   input  logic [3:0]  i_wb_aux_sel,
   input  logic        i_wb_aux_we,
   input  logic        i_wb_aux_stb,
   output logic [31:0] o_wb_aux_rdt,
   output logic        o_wb_aux_ack,
   output logic [31:0] o_wb_mem_adr,
   output logic [31:0] o_wb_mem_dat,
   output logic [3:0]  o_wb_mem_sel,
   output logic        o_wb_mem_we,
   output logic        o_wb_mem_stb,
   input  logic [31:0] i_wb_mem_rdt,
   input  logic        i_wb_mem_ack,
   output logic [1:0]  o_grant,
   output logic        o_err,
   output logic [7:0]  o_err_count
);

   if (timeout_cycles < 2 || timeout_cycles > 255) begin : g_bad_timeout
      $error("servile_wb_sched: timeout_cycles must be in 2..255");
   end

`ifdef SERVILE_WB_SCHED_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, TOUT = 2'd2} state_t;
   localparam logic [7:0] TO_LAST = 8'(timeout_cycles - 1);
   logic [7:0] r_wdog;
   logic [7:0] r_err_count;
   logic       r_tout;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_t;
`endif

   state_t     r_state;
   logic [1:0] r_grant;
   logic [1:0] r_last;
   logic       r_stb;

   logic [2:0] w_req;
   logic [1:0] w_win;
   logic       w_tout;
   logic       w_ack;
   logic [31:0] w_rdt;

   // Round-robin: the master after the last winner has top priority.
   // A lone requester wins whatever the pointer says.
   always_comb begin
      w_req = {i_wb_aux_stb, i_wb_dbus_stb, i_wb_ibus_stb};
      w_win = 2'd0;
      case (r_last)
         2'd0:    w_win = w_req[1] ? 2'd1 : (w_req[2] ? 2'd2 : 2'd0);
         2'd1:    w_win = w_req[2] ? 2'd2 : (w_req[0] ? 2'd0 : 2'd1);
         default: w_win = w_req[0] ? 2'd0 : (w_req[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_grant <= 2'd3;
         r_last  <= 2'd2;
         r_stb   <= 1'b0;
`ifdef SERVILE_WB_SCHED_TIMEOUT_EN
         r_tout      <= 1'b0;
         r_wdog      <= '0;
         r_err_count <= '0;
`endif
      end else begin
`ifdef SERVILE_WB_SCHED_TIMEOUT_EN
         r_tout <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
`ifdef SERVILE_WB_SCHED_TIMEOUT_EN
               // Clearing in IDLE is equivalent to clearing on grant.
               r_wdog <= '0;
`endif
               if (|w_req) begin
                  r_state <= BUSY;
                  r_grant <= w_win;
                  r_last  <= w_win;
                  r_stb   <= 1'b1;
               end
            end
            BUSY: begin
               // An ack in the final BUSY cycle takes precedence over the timeout.
               if (i_wb_mem_ack) begin
                  r_state <= IDLE;
                  r_grant <= 2'd3;
                  r_stb   <= 1'b0;
               end
`ifdef SERVILE_WB_SCHED_TIMEOUT_EN
               else if (r_wdog == TO_LAST) begin
                  r_state <= TOUT;
                  r_stb   <= 1'b0;
                  r_tout  <= 1'b1;
                  if (r_err_count != 8'hFF)
                     r_err_count <= r_err_count + 8'd1;
               end else begin
                  r_wdog <= r_wdog + 8'd1;
               end
`endif
            end
`ifdef SERVILE_WB_SCHED_TIMEOUT_EN
            TOUT: begin
               r_state <= IDLE;
               r_grant <= 2'd3;
            end
`endif
            default: begin
               r_state <= IDLE;
               r_grant <= 2'd3;
               r_stb   <= 1'b0;
            end
         endcase
      end
   end

`ifdef SERVILE_WB_SCHED_TIMEOUT_EN
   assign w_tout      = r_tout;
   assign o_err_count = r_err_count;
`else
   assign w_tout      = 1'b0;
   assign o_err_count = 8'd0;
`endif
   assign o_err = w_tout;

   // Request mux: ibus is read-only, so it presents a full-word read.
   always_comb begin
      o_wb_mem_adr = '0;
      o_wb_mem_dat = '0;
      o_wb_mem_sel = '0;
      o_wb_mem_we  = 1'b0;
      if (r_stb) begin
         case (r_grant)
            2'd0: begin
               o_wb_mem_adr = i_wb_ibus_adr;
               o_wb_mem_sel = 4'hF;
            end
            2'd1: begin
               o_wb_mem_adr = i_wb_dbus_adr;
               o_wb_mem_dat = i_wb_dbus_dat;
               o_wb_mem_sel = i_wb_dbus_sel;
               o_wb_mem_we  = i_wb_dbus_we;
            end
            2'd2: begin
               o_wb_mem_adr = i_wb_aux_adr;
               o_wb_mem_dat = i_wb_aux_dat;
               o_wb_mem_sel = i_wb_aux_sel;
               o_wb_mem_we  = i_wb_aux_we;
            end
            default: begin
               o_wb_mem_adr = '0;
            end
         endcase
      end
   end

   assign o_wb_mem_stb = r_stb;
   assign o_grant      = r_grant;

   // Memory acks are only honoured while stb is out; a timeout acks from TOUT.
   assign w_ack         = (r_stb & i_wb_mem_ack) | w_tout;
   assign o_wb_ibus_ack = w_ack & (r_grant == 2'd0);
   assign o_wb_dbus_ack = w_ack & (r_grant == 2'd1);
   assign o_wb_aux_ack  = w_ack & (r_grant == 2'd2);

   assign w_rdt         = w_tout ? '0 : i_wb_mem_rdt;
   assign o_wb_ibus_rdt = w_rdt;
   assign o_wb_dbus_rdt = w_rdt;
   assign o_wb_aux_rdt  = w_rdt;

endmodule

// File: tb/tb_servile_wb_sched.sv
// Testbench for servile_wb_sched: a table of directed transactions plus
// hand-written sequences for continuous round-robin, reset abort, stray
// acks and the watchdog.
module tb_servile_wb_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ib_adr = '0;
   logic        ib_stb = 1'b0;
   logic [31:0] ib_rdt;
   logic        ib_ack;
   logic [31:0] db_adr = '0, db_dat = '0;
   logic [3:0]  db_sel = '0;
   logic        db_we = 1'b0, db_stb = 1'b0;
   logic [31:0] db_rdt;
   logic        db_ack;
   logic [31:0] ax_adr = '0, ax_dat = '0;
   logic [3:0]  ax_sel = '0;
   logic        ax_we = 1'b0, ax_stb = 1'b0;
   logic [31:0] ax_rdt;
   logic        ax_ack;
   logic [31:0] mem_adr, mem_dat;
   logic [3:0]  mem_sel;
   logic        mem_we, mem_stb;
   logic [31:0] mem_rdt = '0;
   logic        mem_ack;
   logic [1:0]  grant;
   logic        err;
   logic [7:0]  err_cnt;

   int   mem_lat   = 0;     // stb cycles until the memory acks; 0 = never
   logic ack_force = 1'b0;
   int   busy_cnt  = 0;
   int   cyc       = 0;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   servile_wb_sched #(.timeout_cycles(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_wb_ibus_adr(ib_adr), .i_wb_ibus_stb(ib_stb),
      .o_wb_ibus_rdt(ib_rdt), .o_wb_ibus_ack(ib_ack),
      .i_wb_dbus_adr(db_adr), .i_wb_dbus_dat(db_dat), .i_wb_dbus_sel(db_sel),
      .i_wb_dbus_we(db_we), .i_wb_dbus_stb(db_stb),
      .o_wb_dbus_rdt(db_rdt), .o_wb_dbus_ack(db_ack),
      .i_wb_aux_adr(ax_adr), .i_wb_aux_dat(ax_dat), .i_wb_aux_sel(ax_sel),
      .i_wb_aux_we(ax_we), .i_wb_aux_stb(ax_stb),
      .o_wb_aux_rdt(ax_rdt), .o_wb_aux_ack(ax_ack),
      .o_wb_mem_adr(mem_adr), .o_wb_mem_dat(mem_dat), .o_wb_mem_sel(mem_sel),
      .o_wb_mem_we(mem_we), .o_wb_mem_stb(mem_stb),
      .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack),
      .o_grant(grant), .o_err(err), .o_err_count(err_cnt)
   );

   always #5 clk = ~clk;

   // Simple memory: acks in the mem_lat-th consecutive stb cycle.
   assign mem_ack = ack_force || (mem_stb && mem_lat != 0 && busy_cnt == mem_lat - 1);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_stb && !mem_ack) busy_cnt <= busy_cnt + 1;
      else                     busy_cnt <= 0;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic logic ack_of(input logic [1:0] m);
      case (m)
         2'd0:    return ib_ack;
         2'd1:    return db_ack;
         default: return ax_ack;
      endcase
   endfunction

   function automatic logic [31:0] rdt_of(input logic [1:0] m);
      case (m)
         2'd0:    return ib_rdt;
         2'd1:    return db_rdt;
         default: return ax_rdt;
      endcase
   endfunction

   function automatic logic others_ack(input logic [1:0] m);
      case (m)
         2'd0:    return db_ack | ax_ack;
         2'd1:    return ib_ack | ax_ack;
         default: return ib_ack | db_ack;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Checks the current cycle first, then advances up to 10 cycles.
   task automatic wait_stb(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 10 && !ok; n++) begin
         if (mem_stb) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   typedef struct {
      logic [2:0]  req;       // {aux, dbus, ibus}
      logic [31:0] i_adr;
      logic [31:0] d_adr;
      logic [31:0] d_dat;
      logic [3:0]  d_sel;
      logic        d_we;
      logic [31:0] a_adr;
      logic [31:0] a_dat;
      logic [3:0]  a_sel;
      logic        a_we;
      int          lat;
      logic [31:0] rdt;
      logic [1:0]  exp_grant;
   } vec_t;

   vec_t vecs [12];

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] e_adr, e_dat;
      logic [3:0]  e_sel;
      logic        e_we;
      int          n;
      bit          got, stray;
      case (v.exp_grant)
         2'd0:    begin e_adr = v.i_adr; e_dat = '0;      e_sel = 4'hF;    e_we = 1'b0;   end
         2'd1:    begin e_adr = v.d_adr; e_dat = v.d_dat; e_sel = v.d_sel; e_we = v.d_we; end
         default: begin e_adr = v.a_adr; e_dat = v.a_dat; e_sel = v.a_sel; e_we = v.a_we; end
      endcase
      ib_adr = v.i_adr;
      db_adr = v.d_adr; db_dat = v.d_dat; db_sel = v.d_sel; db_we = v.d_we;
      ax_adr = v.a_adr; ax_dat = v.a_dat; ax_sel = v.a_sel; ax_we = v.a_we;
      ib_stb = v.req[0]; db_stb = v.req[1]; ax_stb = v.req[2];
      mem_lat = v.lat; mem_rdt = v.rdt;
      @(negedge clk);
      chk($sformatf("v%0d stb", idx), 32'(mem_stb), 32'd1);
      chk($sformatf("v%0d grant", idx), 32'(grant), 32'(v.exp_grant));
      chk($sformatf("v%0d adr", idx), mem_adr, e_adr);
      chk($sformatf("v%0d dat", idx), mem_dat, e_dat);
      chk($sformatf("v%0d sel", idx), 32'(mem_sel), 32'(e_sel));
      chk($sformatf("v%0d we", idx), 32'(mem_we), 32'(e_we));
      got = 1'b0; stray = 1'b0; n = 0;
      while (!got && n < 20) begin
         if (n > 0) @(negedge clk);
         n++;
         if (mem_ack) got = 1'b1;
         else if (ack_of(v.exp_grant)) stray = 1'b1;
         if (others_ack(v.exp_grant)) stray = 1'b1;
      end
      chk($sformatf("v%0d mem_ack_seen", idx), 32'(got), 32'd1);
      chk($sformatf("v%0d stb_cycles", idx), 32'(n), 32'(v.lat));
      chk($sformatf("v%0d master_ack", idx), 32'(ack_of(v.exp_grant)), 32'd1);
      chk($sformatf("v%0d master_rdt", idx), rdt_of(v.exp_grant), v.rdt);
      chk($sformatf("v%0d stray_ack", idx), 32'(stray), 32'd0);
      ib_stb = 1'b0; db_stb = 1'b0; ax_stb = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d idle_grant", idx), 32'(grant), 32'd3);
      chk($sformatf("v%0d idle_stb", idx), 32'(mem_stb), 32'd0);
   endtask

   initial begin
      logic [1:0] rr_exp [6];
      int  prev_ack, n, pulses;
      bit  ok, bad, got;

      //              req     i_adr         d_adr         d_dat         d_sel    d_we  a_adr         a_dat         a_sel    a_we  lat rdt           grant
      vecs[0]  = '{3'b001, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 4'h0,    1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0,    1'b0, 2, 32'h1111_1111, 2'd0};
      vecs[1]  = '{3'b010, 32'h0000_0000, 32'h2000_0004, 32'hCAFE_F00D, 4'b0011, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'h0,    1'b0, 1, 32'h2222_2222, 2'd1};
      vecs[2]  = '{3'b111, 32'h0000_0200, 32'h0000_0300, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h4000_0000, 32'h1234_5678, 4'b1000, 1'b1, 1, 32'h3333_3333, 2'd2};
      vecs[3]  = '{3'b111, 32'h0000_0204, 32'h0000_0304, 32'hA5A5_0001, 4'b0001, 1'b1, 32'h4000_0004, 32'h8765_4321, 4'b0100, 1'b1, 1, 32'h4444_4444, 2'd0};
      vecs[4]  = '{3'b110, 32'h0000_0208, 32'h0000_0308, 32'hA5A5_0002, 4'b0110, 1'b0, 32'h4000_0008, 32'h0F0F_0F0F, 4'b1100, 1'b1, 2, 32'h5555_5555, 2'd1};
      vecs[5]  = '{3'b101, 32'h0000_020C, 32'h0000_030C, 32'hA5A5_0003, 4'b1001, 1'b1, 32'h4000_000C, 32'hF0F0_F0F0, 4'b0010, 1'b0, 3, 32'h6666_6666, 2'd2};
      vecs[6]  = '{3'b011, 32'h0000_0210, 32'h0000_0310, 32'hA5A5_0004, 4'b1110, 1'b1, 32'h4000_0010, 32'h1357_9BDF, 4'b0111, 1'b1, 1, 32'h7777_7777, 2'd0};
      vecs[7]  = '{3'b101, 32'h0000_0214, 32'h0000_0314, 32'hA5A5_0005, 4'b0101, 1'b0, 32'h4000_0014, 32'h2468_ACE0, 4'b1010, 1'b1, 2, 32'h8888_8888, 2'd2};
      vecs[8]  = '{3'b110, 32'h0000_0218, 32'h0000_0318, 32'hA5A5_0006, 4'b1011, 1'b1, 32'h4000_0018, 32'h0000_FFFF, 4'b1111, 1'b0, 1, 32'h9999_9999, 2'd1};
      vecs[9]  = '{3'b001, 32'h0000_021C, 32'h0000_031C, 32'hA5A5_0007, 4'b0011, 1'b1, 32'h4000_001C, 32'hFFFF_0000, 4'b0001, 1'b1, 2, 32'hAAAA_AAAA, 2'd0};
      vecs[10] = '{3'b100, 32'h0000_0220, 32'h0000_0320, 32'hA5A5_0008, 4'b1100, 1'b0, 32'h4000_0020, 32'hC0DE_C0DE, 4'b0110, 1'b1, 1, 32'hBBBB_BBBB, 2'd2};
      vecs[11] = '{3'b010, 32'h0000_0224, 32'h0000_0324, 32'hA5A5_0009, 4'b1000, 1'b0, 32'h4000_0024, 32'hBEEF_0000, 4'b1001, 1'b0, 3, 32'hCCCC_CCCC, 2'd1};
      rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2;
      rr_exp[3] = 2'd0; rr_exp[4] = 2'd1; rr_exp[5] = 2'd2;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst grant", 32'(grant), 32'd3);
      chk("rst stb", 32'(mem_stb), 32'd0);
      chk("rst acks", 32'({ib_ack, db_ack, ax_ack}), 32'd0);
      chk("rst adr", mem_adr, 32'd0);
      chk("rst dat", mem_dat, 32'd0);
      chk("rst sel_we", 32'({mem_sel, mem_we}), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst err_cnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // All three masters requesting continuously from reset, 1-cycle ack
      do_reset();
      mem_lat = 1; mem_rdt = 32'h7777_0000;
      ib_adr = 32'h10; db_adr = 32'h20; db_we = 1'b0; ax_adr = 32'h30; ax_we = 1'b0;
      ib_stb = 1'b1; db_stb = 1'b1; ax_stb = 1'b1;
      prev_ack = 0;
      for (int k = 0; k < 6; k++) begin
         wait_stb(ok);
         chk($sformatf("rr%0d stb_seen", k), 32'(ok), 32'd1);
         chk($sformatf("rr%0d grant", k), 32'(grant), 32'(rr_exp[k]));
         if (k > 0) chk($sformatf("rr%0d gap", k), 32'(cyc - prev_ack), 32'd2);
         chk($sformatf("rr%0d ack", k), 32'(ack_of(rr_exp[k])), 32'd1);
         prev_ack = cyc;
         @(negedge clk);
      end
      ib_stb = 1'b0; db_stb = 1'b0; ax_stb = 1'b0;
      @(negedge clk);

      // Reset during the 2nd BUSY cycle of an ibus fetch (last becomes 0)
      mem_lat = 0; ib_adr = 32'h500; ib_stb = 1'b1;
      @(negedge clk);
      chk("abort busy1 grant", 32'(grant), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; ib_stb = 1'b0;
      chk("abort stb", 32'(mem_stb), 32'd0);
      chk("abort grant", 32'(grant), 32'd3);
      chk("abort acks", 32'({ib_ack, db_ack, ax_ack}), 32'd0);
      ack_force = 1'b1;
      chk("idle ack ignored", 32'({ib_ack, db_ack, ax_ack}), 32'd0);
      @(negedge clk);
      chk("idle ack ignored 2", 32'({ib_ack, db_ack, ax_ack}), 32'd0);
      ack_force = 1'b0;
      mem_lat = 1; mem_rdt = 32'h0000_5150;
      db_adr = 32'h600; db_we = 1'b0;
      ib_stb = 1'b1; db_stb = 1'b1;
      wait_stb(ok);
      chk("post_rst first grant", 32'(grant), 32'd0);
      chk("post_rst ib ack", 32'(ib_ack), 32'd1);
      ib_stb = 1'b0;
      @(negedge clk);
      wait_stb(ok);
      chk("post_rst second grant", 32'(grant), 32'd1);
      chk("post_rst db ack", 32'(db_ack), 32'd1);
      db_stb = 1'b0;
      @(negedge clk);

`ifdef SERVILE_WB_SCHED_TIMEOUT_EN
      // Ack in the 4th (last) BUSY cycle wins over the timeout
      mem_lat = 4; mem_rdt = 32'h0BAD_CAFE; db_adr = 32'h700; db_stb = 1'b1;
      bad = 1'b0; got = 1'b0; n = 0;
      while (!got && n < 10) begin
         @(negedge clk);
         n++;
         if (err) bad = 1'b1;
         if (mem_ack) got = 1'b1;
      end
      chk("wd4 stb_cycles", 32'(n), 32'd4);
      chk("wd4 db ack", 32'(db_ack), 32'd1);
      chk("wd4 db rdt", db_rdt, 32'h0BAD_CAFE);
      db_stb = 1'b0;
      @(negedge clk);
      if (err) bad = 1'b1;
      chk("wd4 no err", 32'(bad), 32'd0);
      chk("wd4 err_cnt", 32'(err_cnt), 32'd0);

      // No memory ack: 4 BUSY cycles then one TOUT cycle
      mem_lat = 0; mem_rdt = 32'h5A5A_5A5A; db_stb = 1'b1;
      bad = 1'b0;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         if (!mem_stb || err || db_ack) bad = 1'b1;
      end
      chk("wd busy4", 32'(bad), 32'd0);
      @(negedge clk);
      chk("wd tout stb", 32'(mem_stb), 32'd0);
      chk("wd tout ack", 32'(db_ack), 32'd1);
      chk("wd tout rdt", db_rdt, 32'd0);
      chk("wd tout err", 32'(err), 32'd1);
      chk("wd tout err_cnt", 32'(err_cnt), 32'd1);
      chk("wd tout other acks", 32'({ib_ack, ax_ack}), 32'd0);
      pulses = 1;
      for (int t = 0; t < 3000 && pulses < 300; t++) begin
         @(negedge clk);
         if (err) pulses++;
      end
      chk("wd pulses", 32'(pulses), 32'd300);
      chk("wd err_cnt sat", 32'(err_cnt), 32'd255);
      db_stb = 1'b0;
      @(negedge clk);
      chk("wd err single", 32'(err), 32'd0);
`else
      // Without the watchdog, BUSY waits indefinitely
      mem_lat = 0; ax_adr = 32'h800; ax_stb = 1'b1;
      bad = 1'b0;
      for (int b = 0; b < 100; b++) begin
         @(negedge clk);
         if (!mem_stb || ax_ack || err || err_cnt != 8'd0) bad = 1'b1;
      end
      chk("nowd hold", 32'(bad), 32'd0);
      chk("nowd grant", 32'(grant), 32'd2);
      ax_stb = 1'b0;
      do_reset();
      chk("nowd reset stb", 32'(mem_stb), 32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
